// File: rtl/muxn_stage.sv
// N-way channel selector feeding a 2-entry skid buffer; in_ready comes straight
// from registered state so upstream never sees a combinational path from out_ready.
module muxn_stage #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [SELW-1:0]    out_sel,
  output logic               out_oor,
  output logic [7:0]         oor_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
    logic             oor;
  } beat_t;

  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  state_e           state_q, state_d;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic [7:0]       cnt_q, cnt_d;
  beat_t            beat_s;
  logic [WIDTH-1:0] hit_data_s;
  logic             oor_s;
  logic             accept_s;

  assign in_ready  = !reset && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out       = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_oor   = main_q.oor;
  assign oor_count = cnt_q;
  assign accept_s  = in_valid && in_ready;

  // Channel select: AND-OR mux, channel 0 substituted for out-of-range selects
  always_comb begin
    hit_data_s = '0;
    for (int i = 0; i < N; i++) begin
      hit_data_s = hit_data_s | (d[i*WIDTH +: WIDTH] & {WIDTH{s == SELW'(i)}});
    end
    oor_s       = ({1'b0, s} >= N_EXT);
    beat_s.data = oor_s ? d[WIDTH-1:0] : hit_data_s;
    beat_s.sel  = s;
    beat_s.oor  = oor_s;
  end

  // Skid-buffer next state and out-of-range counter
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = beat_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && out_ready) begin
          main_d = beat_s;
        end else if (accept_s) begin
          skid_d  = beat_s;
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (accept_s && beat_s.oor && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
